// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures bytes from the receiver pulse, holds them for AHB pops, drives the UART IRQ.
// Optional build macro UART_RX_FIFO_THRESH_IRQ_EN: occupancy-threshold IRQ plus idle-timeout IRQ.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  wr_valid,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic                  overrun_clr,
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    input  logic [DEPTH_LOG2:0]   irq_thresh,
`endif
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  irq_q, irq_d;
    logic                  push, pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign overrun = overrun_q;
    assign irq     = irq_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = wr_valid & (~full | rd_en);
    assign pop  = rd_en & ~empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Set has priority over clear so a drop in the clear cycle is not lost.
        if (wr_valid & full & ~rd_en) overrun_d = 1'b1;
        else if (overrun_clr)         overrun_d = 1'b0;
    end

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic [15:0]         idle_q, idle_d;
    logic [DEPTH_LOG2:0] thresh_eff;

    assign thresh_eff = (irq_thresh == '0) ? (DEPTH_LOG2 + 1)'(1) : irq_thresh;

    always_comb begin
        idle_d = idle_q;
        if (push | pop)                             idle_d = '0;
        else if (!empty && idle_q != 16'hFFFF)      idle_d = idle_q + 16'd1;
        // The idle term is a single-cycle kick to get a partial burst serviced.
        irq_d = (count_q >= thresh_eff) | ((idle_q == 16'd4096) & ~empty);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`else
    always_comb begin
        irq_d = ~empty;
    end
`endif

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic against a queue-based model.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       RSTn;
    logic       wr_valid, rd_en, overrun_clr;
    logic [7:0] wr_data;
    logic [4:0] irq_thresh;
    logic [7:0] rd_data;
    logic       empty, full, overrun, irq;
    logic [4:0] count;

    int tests = 0;
    int fails = 0;

    // Reference model: ordered byte queue, sticky overrun, and irq as last cycle's non-empty.
    logic [7:0] mq[$];
    logic       m_over;
    logic       m_irq;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .overrun_clr(overrun_clr),
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        .irq_thresh (irq_thresh),
`endif
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overrun    (overrun),
        .irq        (irq)
    );

    function automatic logic [7:0] m_head();
        return (mq.size() == 0) ? 8'h00 : mq[0];
    endfunction

    // Drives one cycle of inputs, advances the model, returns at edge+1.
    task automatic tick(input logic wv, input logic [7:0] wd, input logic re, input logic clr);
        bit m_full, m_empty;
        wr_valid = wv; wr_data = wd; rd_en = re; overrun_clr = clr;
        m_full  = (mq.size() == 16);
        m_empty = (mq.size() == 0);
        m_irq   = !m_empty;
        if (wv && m_full && !re) m_over = 1'b1;
        else if (clr)            m_over = 1'b0;
        if (re && !m_empty)         void'(mq.pop_front());
        if (wv && (!m_full || re))  mq.push_back(wd);
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_en = 1'b0; overrun_clr = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (empty !== 1'b1)   begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
        tests++; if (full !== 1'b0)    begin fails++; $display("FAIL reset_full got %b want 0", full); end
        tests++; if (count !== 5'd0)   begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (rd_data !== 8'h0) begin fails++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
        tests++; if (irq !== 1'b0)     begin fails++; $display("FAIL reset_irq got %b want 0", irq); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        tick(1'b1, 8'h41, 1'b0, 1'b0);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL basic_irq_lat got %b want 0", irq); end
        tick(1'b1, 8'h42, 1'b0, 1'b0);
`ifndef UART_RX_FIFO_THRESH_IRQ_EN
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL basic_irq_rise got %b want 1", irq); end
`endif
        tick(1'b1, 8'h43, 1'b0, 1'b0);
        tests++; if (count !== 5'd3)    begin fails++; $display("FAIL basic_count got %0d want 3", count); end
        tests++; if (rd_data !== 8'h41) begin fails++; $display("FAIL basic_head got %h want 41", rd_data); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (rd_data !== exp_b[i]) begin fails++; $display("FAIL basic_pop%0d got %h want %h", i, rd_data, exp_b[i]); end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        tests++; if (empty !== 1'b1 || rd_data !== 8'h00) begin fails++; $display("FAIL basic_drained empty %b data %h want 1 00", empty, rd_data); end
`ifndef UART_RX_FIFO_THRESH_IRQ_EN
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL basic_irq_hold got %b want 1", irq); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL basic_irq_fall got %b want 0", irq); end
`endif
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'hAA, 1'b0, 1'b0);
        tests++; if (full !== 1'b1 || count !== 5'd16) begin fails++; $display("FAIL ovr_full full %b count %0d want 1 16", full, count); end
        tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", overrun); end
        for (int i = 0; i < 16; i++) begin
            tests++; if (rd_data !== 8'(i)) begin fails++; $display("FAIL ovr_pop%0d got %h want %h", i, rd_data, 8'(i)); end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL ovr_drop got empty %b want 1", empty); end
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_clr got %b want 0", overrun); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'h55, 1'b1, 1'b0);
        tests++; if (count !== 5'd16)   begin fails++; $display("FAIL fpp_count got %0d want 16", count); end
        tests++; if (overrun !== 1'b0)  begin fails++; $display("FAIL fpp_overrun got %b want 0", overrun); end
        tests++; if (rd_data !== 8'h01) begin fails++; $display("FAIL fpp_head got %h want 01", rd_data); end
        for (int i = 0; i < 15; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (rd_data !== 8'h55) begin fails++; $display("FAIL fpp_last got %h want 55", rd_data); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_empty_push_pop();
        tick(1'b1, 8'h77, 1'b1, 1'b0);
        tests++; if (count !== 5'd1 || rd_data !== 8'h77) begin fails++; $display("FAIL epp count %0d data %h want 1 77", count, rd_data); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (count !== 5'd0 || empty !== 1'b1) begin fails++; $display("FAIL epp_idle_pop count %0d empty %b want 0 1", count, empty); end
    endtask

    task automatic test_wrap();
        int maxc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            if (int'(count) > maxc) maxc = int'(count);
            tests++; if (rd_data !== 8'(8'h30 + i)) begin fails++; $display("FAIL wrap%0d got %h want %h", i, rd_data, 8'(8'h30 + i)); end
            tick(1'b0, 8'h00, 1'b1, 1'b0);
        end
        tests++; if (maxc > 2 || count !== 5'd0) begin fails++; $display("FAIL wrap_count max %0d end %0d want <=2 0", maxc, count); end
    endtask

    task automatic test_random();
        int wp, rp;
        for (int c = 0; c < 400; c++) begin
            wp = (c < 200) ? 3 : 1;
            rp = (c < 200) ? 1 : 3;
            tick(($urandom_range(3) < wp), 8'($urandom), ($urandom_range(3) < rp), ($urandom_range(15) == 0));
            tests++;
            if (count !== 5'(mq.size()) || rd_data !== m_head() || overrun !== m_over ||
                empty !== (mq.size() == 0) || full !== (mq.size() == 16)) begin
                fails++;
                $display("FAIL rand_c%0d count %0d/%0d data %h/%h ovr %b/%b empty %b full %b", c,
                         count, mq.size(), rd_data, m_head(), overrun, m_over, empty, full);
            end
`ifndef UART_RX_FIFO_THRESH_IRQ_EN
            tests++; if (irq !== m_irq) begin fails++; $display("FAIL rand_irq_c%0d got %b want %b", c, irq, m_irq); end
`endif
        end
        while (mq.size() != 0) tick(1'b0, 8'h00, 1'b1, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        tests++; if (count !== 5'd5) begin fails++; $display("FAIL mrst_pre count %0d want 5", count); end
        #2 RSTn = 1'b0;
        #1;
        mq.delete(); m_over = 1'b0; m_irq = 1'b0;
        tests++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_data !== 8'h00 || irq !== 1'b0 || overrun !== 1'b0) begin
            fails++; $display("FAIL mrst_async count %0d empty %b full %b data %h irq %b ovr %b", count, empty, full, rd_data, irq, overrun);
        end
        @(posedge clk); #1;
        RSTn = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 8'h00 || irq !== 1'b0) begin
            fails++; $display("FAIL mrst_after count %0d empty %b data %h irq %b", count, empty, rd_data, irq);
        end
    endtask

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    task automatic test_thresh();
        int first_k = -1;
        irq_thresh = 5'd4;
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL thr_below got %b want 0", irq); end
        tick(1'b1, 8'h03, 1'b0, 1'b0);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL thr_lat got %b want 0", irq); end
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL thr_rise got %b want 1", irq); end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        // Idle counter is 0 after the last pop and reaches 4096 after 4096 idle edges; irq follows one edge later.
        for (int k = 1; k <= 4200; k++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0);
            if (irq === 1'b1 && first_k < 0 && k > 2) first_k = k;
        end
        tests++; if (first_k != 4097) begin fails++; $display("FAIL thr_idle first irq at %0d want 4097", first_k); end
        while (mq.size() != 0) tick(1'b0, 8'h00, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        RSTn = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_en = 1'b0; overrun_clr = 1'b0;
        irq_thresh = 5'd4; m_over = 1'b0; m_irq = 1'b0;
        repeat (3) @(posedge clk);
        #1 RSTn = 1'b1;
        test_reset();
        test_basic();
        test_overrun();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap();
        test_random();
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        test_thresh();
`endif
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
